// File: rtl/lo_table_read_sequencer_if.sv
// Handshake/config bundle between the LO table read sequencer and its controller.
// The slave modport is the sequencer; the master modport drives configuration and strobes.
interface lo_table_read_sequencer_if #(
   parameter int unsigned ADDRESS_WIDTH = 10,
   parameter int unsigned WRAP_WIDTH    = 16
);
   logic                     enable;
   logic [ADDRESS_WIDTH-1:0] lastAddr;
   logic                     syncMode;
   logic                     oneShot;
   logic                     sync;
   logic                     clearStatus;
   logic [ADDRESS_WIDTH-1:0] rAddr;
   logic                     rdValid;
   logic                     rdFirst;
   logic                     running;
   logic [WRAP_WIDTH-1:0]    wrapCount;
   logic                     syncMisalign;

   modport master (
      output enable, lastAddr, syncMode, oneShot, sync, clearStatus,
      input  rAddr, rdValid, rdFirst, running, wrapCount, syncMisalign
   );

   modport slave (
      input  enable, lastAddr, syncMode, oneShot, sync, clearStatus,
      output rAddr, rdValid, rdFirst, running, wrapCount, syncMisalign
   );
endinterface

// File: rtl/lo_table_read_sequencer.sv
// Read-address sequencer for the LO table RAM: one read per clock, programmable wrap,
// optional sync start/realign, and valid/first markers aligned to the RAM read latency.
module lo_table_read_sequencer #(
   parameter int unsigned ADDRESS_WIDTH = 10,
   parameter int unsigned RAM_LATENCY   = 1,
   parameter int unsigned WRAP_WIDTH    = 16
) (
   input logic                      clk,
   input logic                      reset,
   lo_table_read_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StArmed = 2'd1,
      StRun   = 2'd2,
      StDone  = 2'd3
   } state_e;

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [ADDRESS_WIDTH-1:0] last_q, last_d;
   logic                     sync_mode_q, sync_mode_d;
   logic                     one_shot_q, one_shot_d;
   logic [WRAP_WIDTH-1:0]    wrap_q, wrap_d;
   logic                     misalign_q, misalign_d;
   logic [RAM_LATENCY-1:0]   valid_q, first_q;

   logic issue, issue_first, at_last, wrap_inc, misalign_set;

   assign issue       = (state_q == StRun);
   assign issue_first = issue && (addr_q == '0);
   assign at_last     = (addr_q == last_q);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      last_d       = last_q;
      sync_mode_d  = sync_mode_q;
      one_shot_d   = one_shot_q;
      wrap_d       = wrap_q;
      misalign_d   = misalign_q;
      wrap_inc     = 1'b0;
      misalign_set = 1'b0;

      if (!bus.enable) begin
         state_d = StIdle;
         addr_d  = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               last_d      = bus.lastAddr;
               sync_mode_d = bus.syncMode;
               one_shot_d  = bus.oneShot;
               addr_d      = '0;
               state_d     = bus.syncMode ? StArmed : StRun;
            end
            StArmed: begin
               addr_d = '0;
               if (bus.sync) state_d = StRun;
            end
            StRun: begin
               // A sync landing on the last entry is just an ordinary wrap.
               if (sync_mode_q && bus.sync && !at_last) begin
                  addr_d       = '0;
                  misalign_set = 1'b1;
               end else if (at_last) begin
                  addr_d   = '0;
                  wrap_inc = 1'b1;
                  if (one_shot_q) state_d = StDone;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
            StDone: begin
               addr_d = '0;
            end
         endcase
      end

      if (bus.clearStatus) begin
         wrap_d     = '0;
         misalign_d = 1'b0;
      end else begin
         if (wrap_inc && (wrap_q != '1)) wrap_d = wrap_q + 1'b1;
         if (misalign_set) misalign_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         last_q      <= '0;
         sync_mode_q <= 1'b0;
         one_shot_q  <= 1'b0;
         wrap_q      <= '0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         last_q      <= last_d;
         sync_mode_q <= sync_mode_d;
         one_shot_q  <= one_shot_d;
         wrap_q      <= wrap_d;
         misalign_q  <= misalign_d;
      end
   end

   // Delay line matching the RAM read latency; keeps draining after enable drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         first_q <= '0;
      end else begin
         valid_q[0] <= issue;
         first_q[0] <= issue_first;
         for (int i = 1; i < int'(RAM_LATENCY); i++) begin
            valid_q[i] <= valid_q[i-1];
            first_q[i] <= first_q[i-1];
         end
      end
   end

   assign bus.rAddr        = addr_q;
   assign bus.rdValid      = valid_q[RAM_LATENCY-1];
   assign bus.rdFirst      = first_q[RAM_LATENCY-1];
   assign bus.running      = (state_q == StRun);
   assign bus.wrapCount    = wrap_q;
   assign bus.syncMisalign = misalign_q;

endmodule
